// File: rtl/dmac_cfg_master.sv
// Programs a DMAC through its register bus for one command, then waits for completion.
// Macro DMAC_CFG_IRQ_WAIT_EN: wait on irq_in (after an interrupt-enable write) instead of polling status.
module dmac_cfg_master #(
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_src,
  input  logic [31:0] cmd_dst,
  input  logic [31:0] cmd_size,
  input  logic [31:0] cmd_mode,
  output logic        M_sel,
  output logic        M_wr,
  output logic [7:0]  M_address,
  output logic [31:0] M_dout,
  input  logic [31:0] M_din,
  input  logic        irq_in,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] ADDR_CLEAR  = 8'h00;
  localparam logic [7:0] ADDR_START  = 8'h01;
  localparam logic [7:0] ADDR_INTEN  = 8'h02;
  localparam logic [7:0] ADDR_SRC    = 8'h03;
  localparam logic [7:0] ADDR_DST    = 8'h04;
  localparam logic [7:0] ADDR_PUSH   = 8'h05;
  localparam logic [7:0] ADDR_SIZE   = 8'h07;
  localparam logic [7:0] ADDR_MODE   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SRC, S_WR_DST, S_WR_SIZE, S_WR_MODE, S_WR_PUSH, S_WR_INTEN,
    S_WR_START, S_POLL_RD, S_POLL_CHK, S_WAIT_IRQ, S_CLEAR, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_src, r_dst, r_size, r_mode;
  logic [15:0] r_poll_cnt;
  logic        r_err;
  logic        r_sel, r_wr, r_done;
  logic [7:0]  r_addr;
  logic [31:0] r_dout;
  logic        w_sel_next, w_wr_next;
  logic [7:0]  w_addr_next;
  logic [31:0] w_dout_next;
  logic [31:0] w_src;
  logic        w_accept, w_waiting, w_limit_hit;
  logic        w_unused;

  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign w_limit_hit = (r_poll_cnt == POLL_LIMIT);

`ifdef DMAC_CFG_IRQ_WAIT_EN
  assign w_waiting = (r_state == S_WAIT_IRQ) && !irq_in;
  assign w_unused  = ^M_din;
`else
  assign w_waiting = (r_state == S_POLL_CHK) && !M_din[0];
  assign w_unused  = ^{irq_in, M_din[31:1]};
`endif

  // The source write is launched on the accept edge, before r_src holds the new value.
  assign w_src = (r_state == S_IDLE) ? cmd_src : r_src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (cmd_valid) w_state_next = S_WR_SRC;
      S_WR_SRC:   w_state_next = S_WR_DST;
      S_WR_DST:   w_state_next = S_WR_SIZE;
      S_WR_SIZE:  w_state_next = S_WR_MODE;
      S_WR_MODE:  w_state_next = S_WR_PUSH;
`ifdef DMAC_CFG_IRQ_WAIT_EN
      S_WR_PUSH:  w_state_next = S_WR_INTEN;
      S_WR_INTEN: w_state_next = S_WR_START;
      S_WR_START: w_state_next = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (irq_in)           w_state_next = S_CLEAR;
        else if (w_limit_hit) w_state_next = S_DONE;
      end
`else
      S_WR_PUSH:  w_state_next = S_WR_START;
      S_WR_START: w_state_next = S_POLL_RD;
      S_POLL_RD:  w_state_next = S_POLL_CHK;
      S_POLL_CHK: begin
        if (M_din[0])         w_state_next = S_CLEAR;
        else if (w_limit_hit) w_state_next = S_DONE;
        else                  w_state_next = S_POLL_RD;
      end
`endif
      S_CLEAR:    w_state_next = S_DONE;
      S_DONE:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registered copy lines up with the state.
  always_comb begin
    w_sel_next  = 1'b0;
    w_wr_next   = 1'b0;
    w_addr_next = 8'h00;
    w_dout_next = 32'h0;
    case (w_state_next)
      S_WR_SRC:   begin w_sel_next = 1'b1; w_wr_next = 1'b1; w_addr_next = ADDR_SRC;   w_dout_next = w_src;  end
      S_WR_DST:   begin w_sel_next = 1'b1; w_wr_next = 1'b1; w_addr_next = ADDR_DST;   w_dout_next = r_dst;  end
      S_WR_SIZE:  begin w_sel_next = 1'b1; w_wr_next = 1'b1; w_addr_next = ADDR_SIZE;  w_dout_next = r_size; end
      S_WR_MODE:  begin w_sel_next = 1'b1; w_wr_next = 1'b1; w_addr_next = ADDR_MODE;  w_dout_next = r_mode; end
      S_WR_PUSH:  begin w_sel_next = 1'b1; w_wr_next = 1'b1; w_addr_next = ADDR_PUSH;  w_dout_next = 32'h1;  end
      S_WR_INTEN: begin w_sel_next = 1'b1; w_wr_next = 1'b1; w_addr_next = ADDR_INTEN; w_dout_next = 32'h1;  end
      S_WR_START: begin w_sel_next = 1'b1; w_wr_next = 1'b1; w_addr_next = ADDR_START; w_dout_next = 32'h1;  end
      S_POLL_RD:  begin w_sel_next = 1'b1; w_addr_next = ADDR_STATUS; end
      S_CLEAR:    begin w_sel_next = 1'b1; w_wr_next = 1'b1; w_addr_next = ADDR_CLEAR; w_dout_next = 32'h1;  end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel  <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= 8'h00;
      r_dout <= 32'h0;
      r_done <= 1'b0;
    end else begin
      r_sel  <= w_sel_next;
      r_wr   <= w_wr_next;
      r_addr <= w_addr_next;
      r_dout <= w_dout_next;
      r_done <= (w_state_next == S_DONE);
    end
  end

  // Counter saturates at POLL_LIMIT: the timeout cycle sets err instead of incrementing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src      <= 32'h0;
      r_dst      <= 32'h0;
      r_size     <= 32'h0;
      r_mode     <= 32'h0;
      r_poll_cnt <= 16'h0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_src      <= cmd_src;
      r_dst      <= cmd_dst;
      r_size     <= cmd_size;
      r_mode     <= cmd_mode;
      r_poll_cnt <= 16'h0;
      r_err      <= 1'b0;
    end else if (w_waiting) begin
      if (w_limit_hit) r_err      <= 1'b1;
      else             r_poll_cnt <= r_poll_cnt + 16'd1;
    end
  end

  // Gated by reset_n so every output reads 0 while reset is held.
  assign cmd_ready = reset_n && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign M_sel     = r_sel;
  assign M_wr      = r_wr;
  assign M_address = r_addr;
  assign M_dout    = r_dout;

endmodule
